// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: segment encodings and a width helper.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // {a,b,c,d,e,f,g,dp}, active-low; the dp column is replaced by the per-digit mask downstream
    localparam logic [7:0] SEG_HEX [16] = '{
        8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
        8'b10011001, 8'b01001001, 8'b01000001, 8'b00011011,
        8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
        8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
    };

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_hex_rom.sv
// Combinational nibble to active-low a..g segment pattern.
module seg7_hex_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nibble][7:1];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: digit scan with blanking gap, paged frame-synchronous snapshot,
// leading-zero suppression and decimal points.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int PAGES     = 2,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 2,
    parameter int PAGE_DIV  = 100000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4*DIGITS*PAGES-1:0]    in_data,
    input  logic                         page_auto,
    input  logic [clog2_min1(PAGES)-1:0] page_sel,
    input  logic                         hold,
    input  logic                         blank_lz,
    input  logic [DIGITS-1:0]            dp_mask,
    output logic [DIGITS-1:0]            sel,
    output logic [7:0]                   out_data,
    output logic [clog2_min1(PAGES)-1:0] page_idx
);

    localparam int CW = clog2_min1(SCAN_DIV);
    localparam int DW = clog2_min1(DIGITS);
    localparam int PW = clog2_min1(PAGES);
    localparam int QW = clog2_min1(PAGE_DIV);
    localparam int NW = 4 * DIGITS;

    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);
    localparam logic [QW-1:0] PCNT_LAST = QW'(PAGE_DIV - 1);

    logic [CW-1:0]     cnt_reg;
    logic [DW-1:0]     digit_reg;
    logic [PW-1:0]     page_reg;
    logic [PW-1:0]     page_next;
    logic [PW-1:0]     page_clamped;
    logic [QW-1:0]     pcnt_reg;
    logic              page_pend_reg;
    logic              page_pend_next;
    logic [NW-1:0]     snap_reg;
    logic              load_pend_reg;
    logic [DIGITS-1:0] sel_reg;
    logic [DIGITS-1:0] sel_next;
    logic [7:0]        seg_reg;
    logic [7:0]        seg_next;

    logic              cnt_wrap;
    logic              frame_end;
    logic              pcnt_wrap;
    logic              dig_blank;
    logic [6:0]        rom_seg;

    // Per-page and per-digit views padded to a power of two, so indexing never leaves the array
    logic [NW-1:0]     page_data [2**PW];
    logic [3:0]        nib       [2**DW];
    logic              zero_from [2**DW];
    logic [2**DW-1:0]  dp_ext;
    logic [DIGITS-1:0] sel_on;

    assign cnt_wrap  = (cnt_reg == CNT_LAST);
    assign frame_end = cnt_wrap && (digit_reg == DIG_LAST);
    assign pcnt_wrap = (pcnt_reg == PCNT_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < 2**PW; gi++) begin : g_page
            if (gi < PAGES) begin : g_real
                assign page_data[gi] = in_data[gi*NW +: NW];
            end else begin : g_pad
                assign page_data[gi] = '0;
            end
        end

        for (gi = 0; gi < 2**DW; gi++) begin : g_nib
            if (gi < DIGITS) begin : g_real
                assign nib[gi]    = snap_reg[gi*4 +: 4];
                assign dp_ext[gi] = dp_mask[gi];
            end else begin : g_pad
                assign nib[gi]    = 4'h0;
                assign dp_ext[gi] = 1'b0;
            end
        end

        // zero_from[k]: nibbles k and above are all zero (pad nibbles count as zero)
        for (gi = 0; gi < 2**DW; gi++) begin : g_lz
            if (gi == 2**DW - 1) begin : g_top
                assign zero_from[gi] = (nib[gi] == 4'h0);
            end else begin : g_chain
                assign zero_from[gi] = (nib[gi] == 4'h0) && zero_from[gi+1];
            end
        end

        for (gi = 0; gi < DIGITS; gi++) begin : g_sel
            assign sel_on[gi] = (digit_reg == DW'(DIGITS - 1 - gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            digit_reg <= '0;
            pcnt_reg  <= '0;
        end else begin
            cnt_reg  <= cnt_wrap ? '0 : cnt_reg + 1'b1;
            pcnt_reg <= pcnt_wrap ? '0 : pcnt_reg + 1'b1;
            if (cnt_wrap) begin
                digit_reg <= (digit_reg == DIG_LAST) ? '0 : digit_reg + 1'b1;
            end
        end
    end

    always_comb begin
        page_clamped = (page_sel > PAGE_LAST) ? PAGE_LAST : page_sel;
        page_next    = page_reg;
        if (frame_end) begin
            if (page_auto) begin
                if (page_pend_reg) begin
                    page_next = (page_reg == PAGE_LAST) ? '0 : page_reg + 1'b1;
                end
            end else begin
                page_next = page_clamped;
            end
        end
        if (PAGES == 1) begin
            page_next = '0;
        end

        // Any number of wraps between frame boundaries collapses into one pending advance
        page_pend_next = page_pend_reg;
        if (!page_auto) begin
            page_pend_next = 1'b0;
        end else if (pcnt_wrap) begin
            page_pend_next = 1'b1;
        end else if (frame_end) begin
            page_pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page_reg      <= '0;
            page_pend_reg <= 1'b0;
            snap_reg      <= '0;
            load_pend_reg <= 1'b1;
        end else begin
            page_reg      <= page_next;
            page_pend_reg <= page_pend_next;
            load_pend_reg <= 1'b0;
            if (load_pend_reg) begin
                snap_reg <= page_data[0];
            end else if (frame_end && !hold) begin
                snap_reg <= page_data[page_next];
            end
        end
    end

    seg7_hex_rom u_rom (
        .nibble (nib[digit_reg]),
        .seg    (rom_seg)
    );

    always_comb begin
        dig_blank = blank_lz && (digit_reg != '0) && zero_from[digit_reg];
        sel_next  = ~sel_on;
        seg_next  = {dig_blank ? 7'h7F : rom_seg, ~dp_ext[digit_reg]};
        if (cnt_reg < BLANK_END) begin
            sel_next = '1;
            seg_next = SEG_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg <= '1;
            seg_reg <= SEG_OFF;
        end else begin
            sel_reg <= sel_next;
            seg_reg <= seg_next;
        end
    end

    assign sel      = sel_reg;
    assign out_data = seg_reg;
    assign page_idx = page_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed and randomized checks of seg7_scan_driver against a time-indexed reference model.
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int P  = 2;
    localparam int S  = 4;
    localparam int B  = 1;
    localparam int PD = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = 32'h8765_4321;
    logic        page_auto = 1'b0;
    logic [0:0]  page_sel = 1'b0;
    logic        hold = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  dp_mask = 4'b0000;
    logic [3:0]  sel;
    logic [7:0]  out_data;
    logic [0:0]  page_idx;

    int total = 0;
    int bad   = 0;

    logic [7:0] hex [16] = '{
        8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
        8'b10011001, 8'b01001001, 8'b01000001, 8'b00011011,
        8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
        8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
    };

    seg7_scan_driver #(
        .DIGITS(D), .PAGES(P), .SCAN_DIV(S), .BLANK_CYC(B), .PAGE_DIV(PD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .page_auto (page_auto),
        .page_sel  (page_sel),
        .hold      (hold),
        .blank_lz  (blank_lz),
        .dp_mask   (dp_mask),
        .sel       (sel),
        .out_data  (out_data),
        .page_idx  (page_idx)
    );

    always #5 clk = ~clk;

    // Reference model: position in the scan follows from the cycle count since reset
    int          m_t    = 0;
    int          m_page = 0;
    int          m_tog  = 0;
    bit          m_pend = 0;
    bit          m_load = 1;
    logic [15:0] m_snap = '0;
    logic [3:0]  e_sel  = 4'b1111;
    logic [7:0]  e_seg  = 8'hFF;
    logic [0:0]  e_pidx = 1'b0;

    always @(posedge clk or posedge rst) begin : mdl
        int slot, dig, np;
        bit fb, wrap, blank;
        if (rst) begin
            m_t = 0; m_page = 0; m_pend = 0; m_load = 1; m_snap = '0;
            e_sel = 4'b1111; e_seg = 8'hFF; e_pidx = 1'b0;
        end else begin
            slot = m_t % S;
            dig  = (m_t / S) % D;
            fb   = ((m_t % (S * D)) == S * D - 1);
            wrap = ((m_t % PD) == PD - 1);
            if (slot < B) begin
                e_sel = 4'b1111;
                e_seg = 8'hFF;
            end else begin
                e_sel = 4'b1111;
                e_sel[D-1-dig] = 1'b0;
                blank = blank_lz && (dig > 0);
                for (int k = dig; k < D; k++) begin
                    if (m_snap[4*k +: 4] != 4'h0) blank = 0;
                end
                e_seg = {blank ? 7'h7F : hex[m_snap[4*dig +: 4]][7:1], ~dp_mask[dig]};
            end
            np = m_page;
            if (fb) begin
                if (page_auto) begin
                    if (m_pend) np = (m_page + 1) % P;
                end else begin
                    np = (int'(page_sel) >= P) ? P - 1 : int'(page_sel);
                end
            end
            if (!page_auto) m_pend = 0;
            else if (wrap) m_pend = 1;
            else if (fb) m_pend = 0;
            if (m_load) m_snap = in_data[15:0];
            else if (fb && !hold) m_snap = in_data[16*np +: 16];
            m_load = 0;
            if (np != m_page) m_tog++;
            m_page = np;
            e_pidx = 1'(np);
            m_t++;
        end
    end

    int         dut_tog = 0;
    logic [0:0] prev_pidx = 1'b0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, got, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(negedge clk);
        chk({tag, "_sel"}, {4'b0, sel}, {4'b0, e_sel});
        chk({tag, "_seg"}, out_data, e_seg);
        chk({tag, "_pidx"}, {7'b0, page_idx}, {7'b0, e_pidx});
        if (page_idx !== prev_pidx) dut_tog++;
        prev_pidx = page_idx;
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // Advance until the last processed edge was a frame boundary
    task automatic to_frame_start(input string tag);
        int guard = 0;
        do begin
            tick(tag);
            guard++;
        end while ((m_t % (S * D)) != 0 && guard < 2 * S * D);
        chk({tag, "_align"}, 8'(m_t % (S * D)), 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int m_tog0, dut_tog0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_sel", {4'b0, sel}, 8'h0F);
        chk("rst_seg", out_data, 8'hFF);
        chk("rst_pidx", {7'b0, page_idx}, 8'h00);
        rst = 1'b0;

        // First frame: blank cycle, then digit 0 = '1' on sel[3]
        tick("f0_e1");
        chk("f0_blank_sel", {4'b0, sel}, 8'b0000_1111);
        tick("f0_e2");
        chk("f0_d0_sel", {4'b0, sel}, 8'b0000_0111);
        chk("f0_d0_seg", out_data, 8'b10011111);
        ticks("f0", 3);
        page_sel = 1'b1;
        tick("f0_e6");
        chk("f0_d1_sel", {4'b0, sel}, 8'b0000_1011);
        chk("f0_d1_seg", out_data, 8'b00100101);
        ticks("f0", 9);
        chk("f0_pidx_hold", {7'b0, page_idx}, 8'h00);
        tick("f0_fb");
        chk("f0_pidx_new", {7'b0, page_idx}, 8'h01);
        ticks("f1", 2);
        chk("f1_d0_sel", {4'b0, sel}, 8'b0000_0111);
        chk("f1_d0_seg", out_data, 8'b01001001);

        // Auto paging with randomized data, hold, masks
        page_auto = 1'b1;
        m_tog0   = m_tog;
        dut_tog0 = dut_tog;
        for (int i = 0; i < 400; i++) begin
            if (i % 8 == 0) begin
                in_data  = $urandom;
                if ($urandom_range(0, 2) == 0) in_data[15:8] = 8'h00;
                hold     = ($urandom_range(0, 3) == 0);
                blank_lz = $urandom_range(0, 1) == 1;
                dp_mask  = 4'($urandom);
                page_sel = 1'($urandom);
            end
            tick("rnd");
        end
        chk("auto_toggles", 8'(dut_tog - dut_tog0), 8'(m_tog - m_tog0));

        // Hold freezes the snapshot across frames
        page_auto = 1'b0;
        page_sel  = 1'b0;
        hold      = 1'b0;
        blank_lz  = 1'b0;
        dp_mask   = 4'b0000;
        in_data   = 32'h8765_4321;
        to_frame_start("hold_a");
        hold    = 1'b1;
        in_data = 32'h0000_0000;
        to_frame_start("hold_b");
        to_frame_start("hold_c");
        ticks("hold_d", 2);
        chk("hold_d0_seg", out_data, 8'b10011111);
        hold = 1'b0;
        to_frame_start("hold_e");
        ticks("hold_f", 2);
        chk("unhold_d0_seg", out_data, 8'b00000011);

        // Leading-zero blanking and decimal point
        in_data  = 32'h0000_0040;
        blank_lz = 1'b1;
        dp_mask  = 4'b1000;
        to_frame_start("lz_a");
        ticks("lz", 2);
        chk("lz_d0_sel", {4'b0, sel}, 8'b0000_0111);
        chk("lz_d0_seg", out_data, 8'b00000011);
        ticks("lz", 4);
        chk("lz_d1_seg", out_data, 8'b10011001);
        ticks("lz", 4);
        chk("lz_d2_seg", out_data, 8'b11111111);
        ticks("lz", 4);
        chk("lz_d3_sel", {4'b0, sel}, 8'b0000_1110);
        chk("lz_d3_seg", out_data, 8'b11111110);

        // Asynchronous reset during a lit slot
        in_data  = 32'h8765_4321;
        blank_lz = 1'b0;
        dp_mask  = 4'b0000;
        page_sel = 1'b1;
        to_frame_start("ar_a");
        ticks("ar_b", 2);
        chk("ar_lit_seg", out_data, 8'b01001001);
        chk("ar_lit_pidx", {7'b0, page_idx}, 8'h01);
        rst = 1'b1;
        #1;
        chk("ar_sel", {4'b0, sel}, 8'h0F);
        chk("ar_seg", out_data, 8'hFF);
        chk("ar_pidx", {7'b0, page_idx}, 8'h00);
        tick("ar_held");
        rst = 1'b0;
        tick("ar_e1");
        chk("ar_e1_sel", {4'b0, sel}, 8'h0F);
        tick("ar_e2");
        chk("ar_e2_sel", {4'b0, sel}, 8'b0000_0111);
        chk("ar_e2_seg", out_data, 8'b10011111);
        chk("ar_e2_pidx", {7'b0, page_idx}, 8'h00);
        ticks("ar_tail", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
